// File: rtl/host_cmd_tx_pkg.sv
// Shared constants, types and frame-byte helper for the host command transmitter.
// Holds the frame layout, field widths and FSM state encoding.
package host_cmd_tx_pkg;

    localparam int unsigned FRAME_LEN         = 8;
    localparam int unsigned IDX_W             = 3;
    localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'hA5;

    localparam int unsigned DTYPE_W = 4;
    localparam int unsigned OP_W    = 5;
    localparam int unsigned OPND_W  = 16;

    // Start bit + 8 data bits + stop bit.
    localparam int unsigned UART_FRAME_BITS = 10;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StSend = 2'd1,
        StWait = 2'd2
    } frame_state_e;

    typedef struct packed {
        logic [DTYPE_W-1:0] dtype;
        logic [OP_W-1:0]    op;
        logic [OPND_W-1:0]  src1;
        logic [OPND_W-1:0]  src2;
    } host_cmd_t;

    // Byte idx of the frame for a captured command; byte 7 is the XOR of bytes 1..6.
    function automatic logic [7:0] frame_byte(input logic [IDX_W-1:0] idx,
                                              input logic [7:0]       sync,
                                              input host_cmd_t        cmd);
        logic [7:0] b1, b2, b3, b4, b5, b6;
        b1 = {{(8 - DTYPE_W){1'b0}}, cmd.dtype};
        b2 = {{(8 - OP_W){1'b0}}, cmd.op};
        b3 = cmd.src1[15:8];
        b4 = cmd.src1[7:0];
        b5 = cmd.src2[15:8];
        b6 = cmd.src2[7:0];
        case (idx)
            3'd0:    frame_byte = sync;
            3'd1:    frame_byte = b1;
            3'd2:    frame_byte = b2;
            3'd3:    frame_byte = b3;
            3'd4:    frame_byte = b4;
            3'd5:    frame_byte = b5;
            3'd6:    frame_byte = b6;
            default: frame_byte = b1 ^ b2 ^ b3 ^ b4 ^ b5 ^ b6;
        endcase
    endfunction

endpackage

// File: rtl/host_cmd_tx_uart_tx_serial.sv
// 8N1 UART byte serializer with baud and bit counters.
// Accepts a new byte in the last clock of a stop bit so bytes can be sent back to back.
module uart_tx_serial
    import host_cmd_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       last,
    output logic       near_last,
    output logic       txd
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CntLast   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CntPenult = CNT_W'(CLKS_PER_BIT - 2);
    localparam logic [3:0]       StopIdx   = 4'(UART_FRAME_BITS - 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
        $error("CLKS_PER_BIT must be at least 2");
    end

    logic             active_q, active_d;
    logic [3:0]       bit_idx_q, bit_idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       shreg_q, shreg_d;

    logic bit_end;
    logic in_data;

    assign bit_end   = (cnt_q == CntLast);
    assign in_data   = (bit_idx_q != 4'd0) && (bit_idx_q != StopIdx);
    assign last      = active_q && (bit_idx_q == StopIdx) && bit_end;
    // One clock of warning lets the frame FSM present the next byte exactly on time.
    assign near_last = active_q && (bit_idx_q == StopIdx) && (cnt_q == CntPenult);

    always_comb begin
        active_d  = active_q;
        bit_idx_d = bit_idx_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        if (start && (!active_q || last)) begin
            active_d  = 1'b1;
            bit_idx_d = 4'd0;
            cnt_d     = '0;
            shreg_d   = data;
        end else if (active_q) begin
            if (bit_end) begin
                cnt_d = '0;
                if (bit_idx_q == StopIdx) begin
                    active_d  = 1'b0;
                    bit_idx_d = 4'd0;
                end else begin
                    bit_idx_d = bit_idx_q + 4'd1;
                end
                if (in_data) begin
                    shreg_d = {1'b0, shreg_q[7:1]};
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        txd = 1'b1;
        if (active_q) begin
            if (bit_idx_q == 4'd0) begin
                txd = 1'b0;
            end else if (in_data) begin
                txd = shreg_q[0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (n_rst) begin
            active_q  <= 1'b0;
            bit_idx_q <= 4'd0;
            cnt_q     <= '0;
            shreg_q   <= 8'h00;
        end else begin
            active_q  <= active_d;
            bit_idx_q <= bit_idx_d;
            cnt_q     <= cnt_d;
            shreg_q   <= shreg_d;
        end
    end

endmodule

// File: rtl/host_cmd_tx.sv
// Host command framer: captures one command and sends it as an 8-byte UART frame
// (sync, dtype, op, src1, src2, XOR checksum).
module host_cmd_tx
    import host_cmd_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter logic [7:0]  SYNC_BYTE    = SYNC_BYTE_DEFAULT
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DTYPE_W-1:0] dtype,
    input  logic [OP_W-1:0]    op,
    input  logic [OPND_W-1:0]  src1,
    input  logic [OPND_W-1:0]  src2,
    output logic               txd,
    output logic               busy,
    output logic               frame_done
);

    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(FRAME_LEN - 1);

    frame_state_e     state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    host_cmd_t        cmd_q, cmd_d;

    logic       ser_start;
    logic [7:0] ser_byte;
    logic       ser_last;
    logic       ser_near_last;
    logic       ser_txd;
    logic       done_pulse;

    // Outputs are forced to their reset values combinationally while reset is held.
    assign in_ready   = !n_rst && (state_q == StIdle);
    assign busy       = !n_rst && (state_q != StIdle);
    assign frame_done = !n_rst && done_pulse;
    assign txd        = n_rst ? 1'b1 : ser_txd;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cmd_d      = cmd_q;
        ser_start  = 1'b0;
        ser_byte   = frame_byte(idx_q, SYNC_BYTE, cmd_q);
        done_pulse = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (in_valid && in_ready) begin
                    cmd_d.dtype = dtype;
                    cmd_d.op    = op;
                    cmd_d.src1  = src1;
                    cmd_d.src2  = src2;
                    // B0 is constant, so the serializer can start on the accept edge.
                    ser_start   = 1'b1;
                    ser_byte    = SYNC_BYTE;
                    idx_d       = '0;
                    state_d     = StWait;
                end
            end
            StSend: begin
                ser_start = 1'b1;
                state_d   = StWait;
            end
            StWait: begin
                if (idx_q == LastIdx) begin
                    if (ser_last) begin
                        done_pulse = 1'b1;
                        idx_d      = '0;
                        state_d    = StIdle;
                    end
                end else if (ser_near_last) begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = StSend;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (n_rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            cmd_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cmd_q   <= cmd_d;
        end
    end

    uart_tx_serial #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_serial (
        .clk       (clk),
        .n_rst     (n_rst),
        .start     (ser_start),
        .data      (ser_byte),
        .last      (ser_last),
        .near_last (ser_near_last),
        .txd       (ser_txd)
    );

endmodule
